// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam int PIPE_PAYLOAD_W = 64;

    // EX/MEM carries an encoded addi x0,x0,0 so a bubble decodes as a real NOP.
    localparam logic [PIPE_PAYLOAD_W-1:0] EXMEM_NOP_PAYLOAD = 64'h0000_0000_0000_0013;
    localparam logic [PIPE_PAYLOAD_W-1:0] MEMWB_NOP_PAYLOAD = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating performance counter; adds 0..3 per cycle, clears synchronously.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [1:0]       inc_amt,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_sum;

    assign w_sum = {1'b0, r_count} + (CNT_W+1)'(inc_amt);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (w_sum[CNT_W]) begin
            r_count <= '1;
        end else begin
            r_count <= w_sum[CNT_W-1:0];
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised valid/ready pipeline stage with optional 2-entry skid buffer,
// flush-to-NOP and saturating stall/bubble/drop counters.
module pipe_skid_stage #(
    parameter int                WIDTH     = 64,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    import pipe_pkg::*;

    occ_t             r_state;
    occ_t             w_state_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_next;
    logic [WIDTH-1:0] w_skid;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_acc;
    logic             w_ret;
    logic [1:0]       w_stall_amt;
    logic [1:0]       w_bubble_amt;
    logic [1:0]       w_drop_amt;

    assign w_out_valid = (r_state != OCC_EMPTY);
    assign w_acc       = in_valid & w_in_ready;
    assign w_ret       = w_out_valid & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        if (flush) begin
            w_state_next = OCC_EMPTY;
            w_main_next  = NOP_VALUE;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_acc) begin
                        w_state_next = OCC_ONE;
                        w_main_next  = in_data;
                    end
                end
                OCC_ONE: begin
                    if (w_acc && w_ret) begin
                        w_main_next = in_data;
                    end else if (w_acc && (SKID != 0)) begin
                        w_state_next = OCC_TWO;
                    end else if (w_ret && !w_acc) begin
                        w_state_next = OCC_EMPTY;
                        w_main_next  = NOP_VALUE;
                    end
                end
                OCC_TWO: begin
                    if (w_ret) begin
                        w_state_next = OCC_ONE;
                        w_main_next  = w_skid;
                    end
                end
                default: begin
                    w_state_next = OCC_EMPTY;
                    w_main_next  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OCC_EMPTY;
            r_main  <= NOP_VALUE;
        end else begin
            r_state <= w_state_next;
            r_main  <= w_main_next;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] r_skid;
            logic [WIDTH-1:0] w_skid_next;
            logic             r_in_ready;

            always_comb begin
                w_skid_next = r_skid;
                if (flush) begin
                    w_skid_next = NOP_VALUE;
                end else if ((r_state == OCC_ONE) && w_acc && !w_ret) begin
                    w_skid_next = in_data;
                end else if ((r_state == OCC_TWO) && w_ret) begin
                    w_skid_next = NOP_VALUE;
                end
            end

            // Registered ready: look ahead at next occupancy so out_ready never reaches in_ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_skid     <= NOP_VALUE;
                    r_in_ready <= 1'b1;
                end else begin
                    r_skid     <= w_skid_next;
                    r_in_ready <= (w_state_next != OCC_TWO);
                end
            end

            assign w_skid     = r_skid;
            assign w_in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_skid     = NOP_VALUE;
            assign w_in_ready = !w_out_valid | out_ready;
        end
    endgenerate

    // Flushed payloads: everything held minus what downstream took, plus any same-cycle accept.
    assign w_stall_amt  = {1'b0, w_out_valid & ~out_ready};
    assign w_bubble_amt = {1'b0, ~w_out_valid & ~flush};
    assign w_drop_amt   = flush ? (2'(r_state) - {1'b0, w_ret} + {1'b0, w_acc}) : 2'd0;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_cnt),
        .inc_amt (w_stall_amt),
        .count   (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_cnt),
        .inc_amt (w_bubble_amt),
        .count   (bubble_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_cnt),
        .inc_amt (w_drop_amt),
        .count   (drop_cnt)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign occupancy = 2'(r_state);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three configurations driven in turn, checked against a
// queue-based model of a bounded FIFO stage with saturating event counters.
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        clr_cnt;

    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_data;
    logic [1:0]  a_occ;
    logic [31:0] a_stall, a_bubble, a_drop;

    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_data;
    logic [1:0]  b_occ;
    logic [31:0] b_stall, b_bubble, b_drop;

    logic        c_in_ready, c_out_valid;
    logic [7:0]  c_out_data;
    logic [1:0]  c_occ;
    logic [3:0]  c_stall, c_bubble, c_drop;

    pipe_skid_stage #(.WIDTH(64), .NOP_VALUE(64'h0), .SKID(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .flush(flush), .clr_cnt(clr_cnt), .occupancy(a_occ),
        .stall_cnt(a_stall), .bubble_cnt(a_bubble), .drop_cnt(a_drop)
    );

    pipe_skid_stage #(.WIDTH(64), .NOP_VALUE(64'h0), .SKID(0), .CNT_W(32)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .flush(flush), .clr_cnt(clr_cnt), .occupancy(b_occ),
        .stall_cnt(b_stall), .bubble_cnt(b_bubble), .drop_cnt(b_drop)
    );

    pipe_skid_stage #(.WIDTH(8), .NOP_VALUE(8'hA5), .SKID(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data[7:0]), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .flush(flush), .clr_cnt(clr_cnt), .occupancy(c_occ),
        .stall_cnt(c_stall), .bubble_cnt(c_bubble), .drop_cnt(c_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          sel;
    logic        m_in_ready, m_out_valid;
    logic [63:0] m_out_data;
    logic [1:0]  m_occ;
    logic [63:0] m_stall, m_bubble, m_drop;

    always_comb begin
        m_in_ready  = a_in_ready;
        m_out_valid = a_out_valid;
        m_out_data  = a_out_data;
        m_occ       = a_occ;
        m_stall     = 64'(a_stall);
        m_bubble    = 64'(a_bubble);
        m_drop      = 64'(a_drop);
        if (sel == 1) begin
            m_in_ready  = b_in_ready;
            m_out_valid = b_out_valid;
            m_out_data  = b_out_data;
            m_occ       = b_occ;
            m_stall     = 64'(b_stall);
            m_bubble    = 64'(b_bubble);
            m_drop      = 64'(b_drop);
        end else if (sel == 2) begin
            m_in_ready  = c_in_ready;
            m_out_valid = c_out_valid;
            m_out_data  = 64'(c_out_data);
            m_occ       = c_occ;
            m_stall     = 64'(c_stall);
            m_bubble    = 64'(c_bubble);
            m_drop      = 64'(c_drop);
        end
    end

    int checks;
    int failures;

    // Reference model of the selected configuration
    logic [63:0] q[$];
    int          cap;
    bit          mdl_skid;
    bit          rdy_reg;
    logic [63:0] nop;
    logic [63:0] mask;
    longint      cmax;
    longint      e_stall, e_bubble, e_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s sel=%0d observed=%h expected=%h", tag, sel, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > cmax) ? cmax : v;
    endfunction

    task automatic configure(input int s);
        sel = s;
        mdl_skid = (s != 1);
        cap      = mdl_skid ? 2 : 1;
        nop      = (s == 2) ? 64'hA5 : 64'h0;
        mask     = (s == 2) ? 64'hFF : '1;
        cmax     = (s == 2) ? 15 : 64'(32'hFFFF_FFFF);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 64'hDEAD;
        out_ready = 1'b0;
        flush = 1'b1;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        q.delete();
        rdy_reg = 1'b1;
        e_stall = 0;
        e_bubble = 0;
        e_drop = 0;
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic ordy,
                        input logic fl, input logic clr);
        int   occ;
        logic mir, acc, ret;
        in_valid = v;
        in_data = d;
        out_ready = ordy;
        flush = fl;
        clr_cnt = clr;
        #1;
        occ = q.size();
        mir = mdl_skid ? rdy_reg : ((occ == 0) || ordy);
        chk("out_valid", 64'(m_out_valid), 64'(occ > 0));
        chk("out_data", m_out_data, (occ > 0) ? q[0] : nop);
        chk("in_ready", 64'(m_in_ready), 64'(mir));
        chk("occupancy", 64'(m_occ), 64'(occ));
        chk("stall_cnt", m_stall, 64'(e_stall));
        chk("bubble_cnt", m_bubble, 64'(e_bubble));
        chk("drop_cnt", m_drop, 64'(e_drop));
        acc = v & mir;
        ret = (occ > 0) & ordy;
        if (clr) begin
            e_stall = 0;
            e_bubble = 0;
            e_drop = 0;
        end else begin
            e_stall  = sat(e_stall + longint'((occ > 0) && !ordy));
            e_bubble = sat(e_bubble + longint'((occ == 0) && !fl));
            if (fl) e_drop = sat(e_drop + longint'(occ) - longint'(ret) + longint'(acc));
        end
        if (ret) begin
            $display("sel=%0d xfer data=%h flush=%0d", sel, q[0], fl);
            void'(q.pop_front());
        end
        if (fl) q.delete();
        else if (acc) q.push_back(d & mask);
        rdy_reg = (q.size() < cap);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 99) < 70), {$urandom, $urandom},
                 1'($urandom_range(0, 99) < rdy_pct),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        clr_cnt = 1'b0;

        // SKID=1, WIDTH=64
        configure(0);
        do_reset();
        chk("rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_in_ready", 64'(m_in_ready), 64'd1);
        chk("rst_drop", m_drop, 64'd0);
        step(1, 64'h11, 1, 0, 0);
        step(1, 64'h22, 1, 0, 0);
        step(1, 64'h33, 1, 0, 0);
        chk("stream_head", m_out_data, 64'h33);
        step(0, 64'h0, 1, 0, 0);
        chk("stream_stall", m_stall, 64'd0);

        step(1, 64'hA, 0, 0, 0);
        step(1, 64'hB, 0, 0, 0);
        chk("skid_occ2", 64'(m_occ), 64'd2);
        chk("skid_not_ready", 64'(m_in_ready), 64'd0);
        step(1, 64'hC, 0, 0, 0);
        step(0, 64'h0, 1, 0, 0);
        step(0, 64'h0, 1, 0, 0);
        chk("skid_ready_back", 64'(m_in_ready), 64'd1);

        step(1, 64'hA, 0, 0, 1);
        step(1, 64'hB, 0, 0, 0);
        step(1, 64'hC, 0, 1, 0);
        chk("flush_two_drop", m_drop, 64'd2);
        chk("flush_two_nop", m_out_data, 64'h0);
        chk("flush_two_occ", 64'(m_occ), 64'd0);
        rand_phase(400, 60);

        // SKID=0, WIDTH=64
        configure(1);
        do_reset();
        step(1, 64'h55, 0, 0, 0);
        step(1, 64'h44, 1, 1, 0);
        chk("noskid_drop", m_drop, 64'd1);
        chk("noskid_occ", 64'(m_occ), 64'd0);
        rand_phase(400, 60);

        // SKID=1, WIDTH=8, NOP=A5, CNT_W=4
        configure(2);
        do_reset();
        chk("c_rst_nop", m_out_data, 64'hA5);
        for (int i = 0; i < 20; i++) step(0, 64'h0, 1, 0, 0);
        chk("bubble_sat", m_bubble, 64'd15);
        step(0, 64'h0, 1, 0, 1);
        chk("bubble_clr", m_bubble, 64'd0);
        rand_phase(400, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Generic parametrised pipeline-stage register, the successor to the fixed-field stage registers between EX, MEM and WB. It carries an opaque payload with a valid/ready handshake and an optional 2-entry skid buffer, so in_ready is registered and has no combinational path from out_ready. It also supports flush-to-NOP and has saturating stall, bubble and drop counters for performance monitoring.

Parameters:
WIDTH, 64, payload width in bits (callers concatenate their stage fields).
NOP_VALUE, '0 (WIDTH bits), payload presented when the stage is empty, after reset and after flush.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  stage holds valid payload
out_ready  in  1  downstream accepts this cycle
out_data  out  WIDTH  head payload; NOP_VALUE when out_valid=0
flush  in  1  discard all contents and any input accepted this cycle
clr_cnt  in  1  synchronous clear of all three counters
occupancy  out  2  entries held (0..2)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0 and flush=0
drop_cnt  out  CNT_W  payloads discarded by flush

Behaviour:
- Reset: state EMPTY, main and skid registers = NOP_VALUE, out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0, all counters=0. Reset overrides flush and clr_cnt.
- Handshake definitions: acc = in_valid & in_ready; ret = out_valid & out_ready. in_data is sampled only on acc. Payload order is strictly FIFO.
- Latency: 1 cycle from acc to out_valid when the stage is empty. Throughput is 1 per cycle in steady state.
- Occupancy states, SKID=1:
  - EMPTY: on acc, go to ONE and main <= in_data.
  - ONE, acc & ret: stay in ONE, main <= in_data.
  - ONE, acc & !ret: go to TWO, skid <= in_data.
  - ONE, !acc & ret: go to EMPTY, main <= NOP_VALUE.
  - ONE, otherwise: hold.
  - TWO: on ret, go to ONE, main <= skid, skid <= NOP_VALUE. Otherwise hold. acc cannot occur in TWO.
- Outputs, SKID=1:
  - in_ready is a register equal to (next_state != TWO).
  - out_valid = (state != EMPTY).
  - out_data = main.
- SKID=0:
  - Only EMPTY and ONE exist.
  - in_ready = !out_valid | out_ready (combinational).
  - Transitions are as above without TWO; skid logic is not instantiated.
- flush (when reset=0):
  - Next state is EMPTY; main and skid <= NOP_VALUE.
  - in_ready is 1 in the following cycle.
  - Any acc in the same cycle is dropped.
  - A ret in the same cycle still completes, since downstream already took the payload.
  - drop_cnt += (occupancy − ret) + acc, saturating.
- Counters:
  - Saturate at 2^CNT_W−1 and never wrap.
  - clr_cnt zeroes all three; if clr_cnt is asserted in the same cycle as an increment, the result is 0.
- Holding rules:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid never deasserts without ret or flush.
- occupancy is registered: EMPTY=0, ONE=1, TWO=2.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum logic [1:0] occ_t {OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2};
  - the shared NOP payload constants for EX/MEM and MEM/WB.
- One sub-module, pipe_sat_counter (parameter CNT_W; inputs inc_amt[1:0] and clr), instantiated three times.

Test Plan:
- Reset with WIDTH=64, NOP_VALUE=0 → out_valid=0, out_data=0, in_ready=1, occupancy=0, all counters 0.
- Stream 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 → the same values appear on out_data one cycle after each acc; stall_cnt stays 0.
- SKID=1: out_ready=0 while sending 0xA, then 0xB → occupancy=2 and in_ready=0 on the next cycle; stall_cnt increments each cycle. Raising out_ready delivers 0xA then 0xB, and in_ready returns to 1.
- Stage at TWO with flush=1 and in_valid=1 in the same cycle → next cycle EMPTY, out_data=NOP_VALUE, drop_cnt=2 (in_ready was 0 in TWO, so no acc).
- SKID=0 at ONE: ret plus acc of 0x44 with flush=1 → ret completes, 0x44 is dropped, drop_cnt=1, state EMPTY.
- CNT_W=4: hold out_valid=0 for 20 cycles → bubble_cnt saturates at 15. A single clr_cnt cycle then zeroes it.
